// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : Handshake bundle for the sequential binary-to-BCD converter.
//            There is one valid/ready pair on the input side and one on the
//            output side. The bundle also carries the busy status.
// Ports    : master - producer/consumer side (drives in_valid, bin, out_ready)
//            slave  - converter side (drives in_ready, out_valid, bcd, busy)
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_W-1:0]        bin;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    busy;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, busy
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential shift-and-add-3 (double-dabble) binary-to-BCD
//            converter. It processes one input bit per clock, so a result
//            takes BIN_W cycles. Conversions do not overlap.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset
//            bus - bin2bcd_seq_if.slave:
//                  in_valid/in_ready/bin    accept side
//                  out_valid/out_ready/bcd  result side (digit 0 in [3:0])
//                  busy                     high while shifting
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int C_BCD_W = 4 * BCD_DIGITS;
  localparam int C_W     = C_BCD_W + BIN_W;
  localparam int C_CW    = $clog2(BIN_W + 1);

  localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(BIN_W);
  localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);

  function automatic logic [63:0] f_pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] C_DEC_RANGE = f_pow10(BCD_DIGITS);
  localparam logic [63:0] C_BIN_RANGE = 64'd1 << BIN_W;

  // Refuse to build a converter whose result field cannot hold every input.
  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (C_DEC_RANGE < C_BIN_RANGE) begin : g_bad_digits
      $error("bin2bcd_seq: BCD_DIGITS=%0d too small for BIN_W=%0d", BCD_DIGITS, BIN_W);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_W-1:0]     r_work;
  logic [C_W-1:0]     w_work_nxt;
  logic [C_CW-1:0]    r_cnt;
  logic [C_CW-1:0]    w_cnt_nxt;
  logic [C_BCD_W-1:0] r_bcd;
  logic [C_BCD_W-1:0] w_bcd_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;

  logic [C_W-1:0]     w_adj;
  logic [C_W-1:0]     w_shift;

  // The BCD field sits above the binary field in the working register.
  // A digit that is 5 or more becomes 10 or more after the coming shift.
  // Adding 3 first makes the shift carry it correctly into the next digit.
  generate
    for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_digit
      logic [3:0] w_dig;
      assign w_dig = r_work[BIN_W + 4*k +: 4];
      assign w_adj[BIN_W + 4*k +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end
  endgenerate

  assign w_adj[BIN_W-1:0] = r_work[BIN_W-1:0];
  assign w_shift          = {w_adj[C_W-2:0], 1'b0};

  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_bcd_nxt       = r_bcd;
    w_out_valid_nxt = r_out_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_work_nxt  = {{C_BCD_W{1'b0}}, bus.bin};
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_work_nxt = w_shift;
        w_cnt_nxt  = r_cnt - C_CNT_ONE;
        // This is the last bit. Publish the post-shift digit field now,
        // so out_valid rises exactly BIN_W edges after the accept.
        if (r_cnt == C_CNT_ONE) begin
          w_bcd_nxt       = w_shift[C_W-1 -: C_BCD_W];
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bcd       <= w_bcd_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.out_valid = r_out_valid;
  assign bus.bcd       = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq. It builds two instances,
//            an 8-bit/3-digit one and a 16-bit/5-digit one. Expected results
//            are queued when an input is accepted. They are compared, along
//            with the latency, when out_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq_if #(.BIN_W(8),  .BCD_DIGITS(3)) if8 ();
  bin2bcd_seq_if #(.BIN_W(16), .BCD_DIGITS(5)) if16 ();

  bin2bcd_seq #(.BIN_W(8), .BCD_DIGITS(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  bin2bcd_seq #(.BIN_W(16), .BCD_DIGITS(5)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  typedef struct {
    logic [19:0] exp;
    int          acc;
  } sb_t;

  typedef struct {
    int unsigned val;
    logic [19:0] exp;
  } vec_t;

  sb_t q8[$];
  sb_t q16[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Result monitors. A rising out_valid is a new result, so a held result
  // is checked only once.
  logic prev_ov8  = 1'b0;
  logic prev_ov16 = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (if8.out_valid && !prev_ov8) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 32'(if8.bcd), 32'hFFFF_FFFF);
      end else begin
        e = q8.pop_front();
        chk("bcd8", 32'(if8.bcd), 32'(e.exp));
        chk("latency8", 32'(cyc), 32'(e.acc + 8));
      end
    end
    prev_ov8 = if8.out_valid;
  end

  always @(negedge clk) begin
    sb_t e;
    if (if16.out_valid && !prev_ov16) begin
      if (q16.size() == 0) begin
        chk("unexpected_out16", 32'(if16.bcd), 32'hFFFF_FFFF);
      end else begin
        e = q16.pop_front();
        chk("bcd16", 32'(if16.bcd), 32'(e.exp));
        chk("latency16", 32'(cyc), 32'(e.acc + 16));
      end
    end
    prev_ov16 = if16.out_valid;
  end

  // The driver tasks are called at a negedge. The accept happens at the
  // following posedge.
  task automatic send8(input logic [7:0] v, input logic [19:0] exp);
    int n = 0;
    while (!if8.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait8", 32'(if8.in_ready), 32'd1);
    if8.in_valid = 1'b1;
    if8.bin      = v;
    q8.push_back('{exp: exp, acc: cyc + 1});
    @(negedge clk);
    if8.in_valid = 1'b0;
    if8.bin      = 8'($urandom);
  endtask

  task automatic send16(input logic [15:0] v, input logic [19:0] exp);
    int n = 0;
    while (!if16.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait16", 32'(if16.in_ready), 32'd1);
    if16.in_valid = 1'b1;
    if16.bin      = v;
    q16.push_back('{exp: exp, acc: cyc + 1});
    @(negedge clk);
    if16.in_valid = 1'b0;
    if16.bin      = 16'($urandom);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      chk("timeout8", 32'(q8.size()), 32'd0);
      q8.delete();
    end
  endtask

  task automatic drain16();
    int n = 0;
    while (q16.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) begin
      chk("timeout16", 32'(q16.size()), 32'd0);
      q16.delete();
    end
  endtask

  vec_t t8[6];
  vec_t t16[5];

  initial begin
    int n;

    t8[0]  = '{255, 20'h00255};
    t8[1]  = '{0,   20'h00000};
    t8[2]  = '{9,   20'h00009};
    t8[3]  = '{10,  20'h00010};
    t8[4]  = '{100, 20'h00100};
    t8[5]  = '{199, 20'h00199};
    t16[0] = '{65535, 20'h65535};
    t16[1] = '{10000, 20'h10000};
    t16[2] = '{9,     20'h00009};
    t16[3] = '{12345, 20'h12345};
    t16[4] = '{0,     20'h00000};

    if8.in_valid   = 1'b0;
    if8.bin        = '0;
    if8.out_ready  = 1'b1;
    if16.in_valid  = 1'b0;
    if16.bin       = '0;
    if16.out_ready = 1'b1;
    rst            = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready8",  32'(if8.in_ready),  32'd1);
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("rst_busy8",      32'(if8.busy),      32'd0);
    chk("rst_bcd8",       32'(if8.bcd),       32'd0);
    chk("rst_in_ready16", 32'(if16.in_ready), 32'd1);
    chk("rst_bcd16",      32'(if16.bcd),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors.
    foreach (t8[i]) begin
      send8(8'(t8[i].val), t8[i].exp);
      drain8();
    end
    foreach (t16[i]) begin
      send16(16'(t16[i].val), t16[i].exp);
      drain16();
    end

    // Exhaustive 8-bit sweep against the decimal model.
    for (int i = 0; i < 256; i++) begin
      send8(8'(i), to_bcd(i));
      drain8();
    end

    // Backpressure: the result must hold while out_ready is low.
    if8.out_ready = 1'b0;
    send8(8'd137, 20'h00137);
    n = 0;
    while (!if8.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 32'(if8.out_valid), 32'd1);
      chk("bp_bcd",       32'(if8.bcd),       32'h137);
      chk("bp_in_ready",  32'(if8.in_ready),  32'd0);
      @(negedge clk);
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(if8.out_valid), 32'd0);
    chk("bp_release_ready", 32'(if8.in_ready),  32'd1);
    chk("bp_bcd_kept",      32'(if8.bcd),       32'h137);

    // Busy rejection: in_valid pulsed during SHIFT must be ignored.
    send8(8'd42, 20'h00042);
    @(negedge clk);
    chk("busy_in_ready", 32'(if8.in_ready), 32'd0);
    chk("busy_flag",     32'(if8.busy),     32'd1);
    if8.in_valid = 1'b1;
    if8.bin      = 8'd200;
    @(negedge clk);
    if8.in_valid = 1'b0;
    drain8();
    repeat (20) @(negedge clk);
    chk("busy_bcd_final", 32'(if8.bcd), 32'h042);

    // Reset during a conversion: discard it, then convert normally.
    send8(8'd199, 20'h00199);
    repeat (4) @(negedge clk);
    chk("midrst_busy", 32'(if8.busy), 32'd1);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(if8.in_ready),  32'd1);
    chk("midrst_busy_low",  32'(if8.busy),      32'd0);
    chk("midrst_bcd",       32'(if8.bcd),       32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_result", 32'(if8.out_valid), 32'd0);
    send8(8'd58, 20'h00058);
    drain8();
    repeat (3) @(negedge clk);

    chk("sb_empty8",  32'(q8.size()),  32'd0);
    chk("sb_empty16", 32'(q16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    bad++;
    $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Generalises the 8-bit combinational bin2bcd to any input width from 4 to 32 bits.
- Spreads the conversion over BIN_W clock cycles instead of one large combinational cone.
- Provides valid/ready handshakes on input and output so it can sit between streaming blocks, for example a counter feeding a 7-segment or UART display path.

Parameters:
- BIN_W, 8, binary input width; legal range 4..32.
- BCD_DIGITS, 3, number of 4-bit BCD output digits. Elaboration must fail via $error if 10**BCD_DIGITS < 2**BIN_W.

Ports:
- clk  input  1  system clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bin is valid.
- in_ready  output  1  block can accept a new value.
- bin  input  BIN_W  unsigned binary value.
- out_valid  output  1  bcd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*BCD_DIGITS  packed BCD result, digit 0 (units) in [3:0].
- busy  output  1  a conversion is in progress (state SHIFT).

Behaviour:
- Reset: rst sampled high at a rising edge gives:
  - state IDLE;
  - in_ready=1, out_valid=0, busy=0;
  - bcd=0, shift register=0, bit counter=0.
  - This applies in any state, including mid-conversion; the conversion in flight is discarded and no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge where in_valid=1. On that edge:
    - load the working register with {BCD_DIGITS*4 zeros, bin};
    - set counter=BIN_W;
    - go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - On each edge:
    - every BCD digit in the working register that is >=5 gets +3 (all digits in parallel, combinational);
    - then the whole register shifts left by 1;
    - counter decrements.
  - On the edge where counter goes 1->0:
    - the post-shift upper 4*BCD_DIGITS bits are written to bcd;
    - out_valid<=1;
    - go to DONE.
  - in_valid is ignored (not captured) while in SHIFT.
- DONE:
  - out_valid=1; in_ready=0; bcd is stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - While out_ready=0: hold indefinitely, with bcd and out_valid unchanged.
- Latency: out_valid rises exactly BIN_W edges after the accept edge.
- Throughput: with out_ready tied high, one result every BIN_W+2 cycles (accept, BIN_W shifts, release). There is no overlap of consecutive conversions.
- bcd keeps its last result after returning to IDLE, until the next completion overwrites it.
- Arithmetic rules:
  - Input is unsigned; no sign handling.
  - Digits never exceed 9 at out_valid.
  - Unused high digits read 0. Example: BIN_W=8, BCD_DIGITS=4 gives digit 3 = 0.
- bin may change after the accept edge without affecting the result.

Test Plan:
- Exhaustive sweep, BIN_W=8, BCD_DIGITS=3, out_ready=1: for each i in 0..255, drive bin=i with in_valid -> bcd digits equal i/100, (i/10)%10, i%10. Example: 255 -> 12'h255, 0 -> 12'h000. out_valid occurs exactly 8 cycles after accept; error count must be 0.
- Wide config, BIN_W=16, BCD_DIGITS=5:
  - 65535 -> 20'h65535 after 16 cycles;
  - 10000 -> 20'h10000;
  - 9 -> 20'h00009.
- Backpressure, BIN_W=8: convert 137 with out_ready=0 for 20 cycles -> out_valid and bcd=12'h137 held throughout, in_ready=0; raise out_ready -> out_valid drops next edge and in_ready=1.
- Busy rejection: accept 42; pulse in_valid with bin=200 during SHIFT -> result 12'h042, and no second out_valid appears without a new accept in IDLE.
- Reset mid-operation: accept 199, assert rst at shift cycle 4 -> next edge gives IDLE, out_valid=0, bcd=0; the following accept of 58 yields 12'h058 with normal latency.
- Parameter guard: elaborate with BIN_W=10, BCD_DIGITS=3 -> $error at elaboration (1023 needs 4 digits).
